// File: rtl/logic_axi4_stream_downsizer_compact_pkg.sv
// Shared types and helpers for the AXI4-Stream downsizer.
// LOGIC_AXI4_STREAM_DOWNSIZER_COMPACT_SKIP_NULL_EN turns on null-chunk skipping.
package logic_axi4_stream_downsizer_compact_pkg;
  localparam int MAX_CHUNKS = 256;

`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_COMPACT_SKIP_NULL_EN
  localparam bit SKIP_NULL_EN = 1'b1;
`else
  localparam bit SKIP_NULL_EN = 1'b0;
`endif

  typedef logic [7:0] idx_t;
  typedef struct packed {
    logic found;
    idx_t idx;
  } chunk_sel_t;
  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  function automatic int ratio(int rx_bytes, int tx_bytes);
    return (tx_bytes > 0) ? rx_bytes / tx_bytes : 1;
  endfunction

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest set mask bit at or above position from; found=0 when none.
  function automatic chunk_sel_t next_chunk(logic [MAX_CHUNKS-1:0] mask, logic [8:0] from);
    chunk_sel_t sel;
    sel = '0;
    for (int i = MAX_CHUNKS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        sel.found = 1'b1;
        sel.idx   = idx_t'(i);
      end
    end
    return sel;
  endfunction
endpackage

// File: rtl/logic_axi4_stream_if.sv
// Plain AXI4-Stream signal bundle used inside the downsizer.
interface logic_axi4_stream_if #(
  parameter int DATA_BYTES = 2,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_BYTES*8-1:0] tdata;
  logic [DATA_BYTES-1:0]   tstrb;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [ID_WIDTH-1:0]     tid;
endinterface

// File: rtl/logic_axi4_stream_downsizer_compact_select.sv
// Chunk mux for the held beat plus the priority encoders that pick the
// next emitted chunk (held beat) and the first emitted chunk (incoming beat).
module logic_axi4_stream_downsizer_compact_select
  import logic_axi4_stream_downsizer_compact_pkg::*;
#(
  parameter int RX_TDATA_BYTES = 8,
  parameter int TX_TDATA_BYTES = 2,
  parameter int TX_TUSER_WIDTH = 1,
  parameter int N              = 4,
  parameter int IDX_W          = 2
) (
  input  logic [RX_TDATA_BYTES*8-1:0] data,
  input  logic [RX_TDATA_BYTES-1:0]   strb,
  input  logic [RX_TDATA_BYTES-1:0]   keep,
  input  logic [N*TX_TUSER_WIDTH-1:0] user,
  input  logic [RX_TDATA_BYTES-1:0]   rx_keep,
  input  logic [IDX_W-1:0]            idx,
  output logic [TX_TDATA_BYTES*8-1:0] chunk_data,
  output logic [TX_TDATA_BYTES-1:0]   chunk_strb,
  output logic [TX_TDATA_BYTES-1:0]   chunk_keep,
  output logic [TX_TUSER_WIDTH-1:0]   chunk_user,
  output logic                        final_chunk,
  output logic [IDX_W-1:0]            next_idx,
  output logic                        first_found,
  output logic [IDX_W-1:0]            first_idx
);
  localparam int TB = TX_TDATA_BYTES;

  logic [MAX_CHUNKS-1:0] hold_mask;
  logic [MAX_CHUNKS-1:0] rx_mask;
  chunk_sel_t            sel_next;
  chunk_sel_t            sel_first;

  // Without skipping every chunk counts as non-null, so the encoder simply steps idx+1.
  always_comb begin
    hold_mask = '0;
    rx_mask   = '0;
    for (int k = 0; k < N; k++) begin
      hold_mask[k] = !SKIP_NULL_EN || (|keep[k*TB +: TB]);
      rx_mask[k]   = !SKIP_NULL_EN || (|rx_keep[k*TB +: TB]);
    end
  end

  always_comb begin
    sel_next  = next_chunk(hold_mask, 9'(idx) + 9'd1);
    sel_first = next_chunk(rx_mask, 9'd0);
  end

  assign chunk_data  = data[int'(idx)*TB*8 +: TB*8];
  assign chunk_strb  = strb[int'(idx)*TB +: TB];
  assign chunk_keep  = keep[int'(idx)*TB +: TB];
  assign chunk_user  = user[int'(idx)*TX_TUSER_WIDTH +: TX_TUSER_WIDTH];
  assign final_chunk = !sel_next.found;
  assign next_idx    = IDX_W'(sel_next.idx);
  assign first_found = sel_first.found;
  assign first_idx   = IDX_W'(sel_first.idx);
endmodule

// File: rtl/logic_axi4_stream_downsizer_compact.sv
// AXI4-Stream width divider: each RX beat leaves as N = RX/TX chunks, LSB chunk first.
// Define LOGIC_AXI4_STREAM_DOWNSIZER_COMPACT_SKIP_NULL_EN to drop all-null chunks.
//   state | meaning
//   EMPTY | no beat held, tx_tvalid low, ready to load
//   HOLD  | beat held, chunk idx presented on tx
module logic_axi4_stream_downsizer_compact
  import logic_axi4_stream_downsizer_compact_pkg::*;
#(
  parameter int RX_TDATA_BYTES = 8,
  parameter int TX_TDATA_BYTES = 2,
  parameter int TX_TUSER_WIDTH = 1,
  parameter int RX_TUSER_WIDTH = ratio(RX_TDATA_BYTES, TX_TDATA_BYTES) * TX_TUSER_WIDTH,
  parameter int TDEST_WIDTH    = 1,
  parameter int TID_WIDTH      = 1,
  parameter int USE_TKEEP      = 1,
  parameter int USE_TSTRB      = 1,
  parameter int USE_TLAST      = 1
) (
  input  logic                        aclk,
  input  logic                        areset_n,
  input  logic                        rx_tvalid,
  output logic                        rx_tready,
  input  logic [RX_TDATA_BYTES*8-1:0] rx_tdata,
  input  logic [RX_TDATA_BYTES-1:0]   rx_tstrb,
  input  logic [RX_TDATA_BYTES-1:0]   rx_tkeep,
  input  logic                        rx_tlast,
  input  logic [RX_TUSER_WIDTH-1:0]   rx_tuser,
  input  logic [TDEST_WIDTH-1:0]      rx_tdest,
  input  logic [TID_WIDTH-1:0]        rx_tid,
  output logic                        tx_tvalid,
  input  logic                        tx_tready,
  output logic [TX_TDATA_BYTES*8-1:0] tx_tdata,
  output logic [TX_TDATA_BYTES-1:0]   tx_tstrb,
  output logic [TX_TDATA_BYTES-1:0]   tx_tkeep,
  output logic                        tx_tlast,
  output logic [TX_TUSER_WIDTH-1:0]   tx_tuser,
  output logic [TDEST_WIDTH-1:0]      tx_tdest,
  output logic [TID_WIDTH-1:0]        tx_tid
);
  localparam int N     = ratio(RX_TDATA_BYTES, TX_TDATA_BYTES);
  localparam int IDX_W = idx_width(N);

  if (RX_TDATA_BYTES < 1 || TX_TDATA_BYTES < 1 ||
      (RX_TDATA_BYTES % ((TX_TDATA_BYTES < 1) ? 1 : TX_TDATA_BYTES)) != 0 ||
      N > MAX_CHUNKS || RX_TUSER_WIDTH != N * TX_TUSER_WIDTH) begin : g_bad_cfg
    $fatal(1, "downsizer: RX_TDATA_BYTES must be a positive multiple of TX_TDATA_BYTES");
  end

  state_t                      state;
  logic                        ready_en;
  logic [IDX_W-1:0]            idx;
  logic [RX_TDATA_BYTES*8-1:0] beat_data;
  logic [RX_TDATA_BYTES-1:0]   beat_strb;
  logic [RX_TDATA_BYTES-1:0]   beat_keep;
  logic [RX_TUSER_WIDTH-1:0]   beat_user;
  logic                        beat_last;
  logic [TDEST_WIDTH-1:0]      beat_dest;
  logic [TID_WIDTH-1:0]        beat_id;
  logic [RX_TDATA_BYTES-1:0]   rx_keep_eff;
  logic                        sel_final;
  logic [IDX_W-1:0]            sel_next_idx;
  logic                        sel_first_found;
  logic [IDX_W-1:0]            sel_first_idx;
  logic                        rx_hs;
  logic                        tx_hs;
  logic                        rx_last_eff;

  logic_axi4_stream_if #(
    .DATA_BYTES(TX_TDATA_BYTES), .USER_WIDTH(TX_TUSER_WIDTH),
    .DEST_WIDTH(TDEST_WIDTH), .ID_WIDTH(TID_WIDTH)
  ) tx_if ();

  logic_axi4_stream_downsizer_compact_select #(
    .RX_TDATA_BYTES(RX_TDATA_BYTES), .TX_TDATA_BYTES(TX_TDATA_BYTES),
    .TX_TUSER_WIDTH(TX_TUSER_WIDTH), .N(N), .IDX_W(IDX_W)
  ) u_select (
    .data(beat_data), .strb(beat_strb), .keep(beat_keep), .user(beat_user),
    .rx_keep(rx_keep_eff), .idx(idx),
    .chunk_data(tx_if.tdata), .chunk_strb(tx_if.tstrb), .chunk_keep(tx_if.tkeep),
    .chunk_user(tx_if.tuser), .final_chunk(sel_final), .next_idx(sel_next_idx),
    .first_found(sel_first_found), .first_idx(sel_first_idx)
  );

  assign rx_keep_eff  = (USE_TKEEP != 0) ? rx_tkeep : '1;
  assign rx_last_eff  = (USE_TLAST != 0) && rx_tlast;
  assign tx_if.tvalid = (state == HOLD);
  assign tx_if.tready = tx_tready;
  assign tx_if.tlast  = tx_if.tvalid && beat_last && sel_final;
  assign tx_if.tdest  = beat_dest;
  assign tx_if.tid    = beat_id;
  assign tx_hs        = tx_if.tvalid && tx_if.tready;
  // Reload in the same cycle the final chunk leaves keeps the output gap-free.
  assign rx_tready    = ready_en && ((state == EMPTY) || (tx_hs && sel_final));
  assign rx_hs        = rx_tvalid && rx_tready;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= EMPTY;
      ready_en  <= 1'b0;
      idx       <= '0;
      beat_data <= '0;
      beat_strb <= '0;
      beat_keep <= '0;
      beat_user <= '0;
      beat_last <= 1'b0;
      beat_dest <= '0;
      beat_id   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (rx_hs) begin
        beat_data <= rx_tdata;
        beat_strb <= (USE_TSTRB != 0) ? rx_tstrb : '1;
        beat_keep <= rx_keep_eff;
        beat_user <= rx_tuser;
        beat_last <= rx_last_eff;
        beat_dest <= rx_tdest;
        beat_id   <= rx_tid;
        if (sel_first_found) begin
          state <= HOLD;
          idx   <= sel_first_idx;
        end else if (rx_last_eff) begin
          state <= HOLD;  // all-null closing beat still carries tlast on chunk 0
          idx   <= '0;
        end else begin
          state <= EMPTY;
          idx   <= '0;
        end
      end else if (tx_hs) begin
        if (sel_final) begin
          state <= EMPTY;
          idx   <= '0;
        end else begin
          idx <= sel_next_idx;
        end
      end
    end
  end

  assign tx_tvalid = tx_if.tvalid;
  assign tx_tdata  = tx_if.tdata;
  assign tx_tstrb  = tx_if.tstrb;
  assign tx_tkeep  = tx_if.tkeep;
  assign tx_tlast  = (USE_TLAST != 0) && tx_if.tlast;
  assign tx_tuser  = tx_if.tuser;
  assign tx_tdest  = tx_if.tdest;
  assign tx_tid    = tx_if.tid;
endmodule
